// File: rtl/trigger_channel_scaler_v5_if.sv
// Bundle for one trigger channel: conditioning controls in, trigger and scaler outputs out.
`timescale 1ns/1ps
interface trigger_channel_scaler_v5_if #(
   parameter int unsigned TRIG_ONESHOT_BITS   = 4,
   parameter int unsigned TRIG_DELAY_VAL_BITS = 4
);
   logic                           trigger_i;
   logic                           power_i;
   logic                           mask_i;
   logic                           slow_ce_i;
   logic                           sync_i;
   logic [TRIG_ONESHOT_BITS-1:0]   trig_oneshot_i;
   logic [TRIG_DELAY_VAL_BITS-1:0] delay_i;
   logic                           trig_p_o;
   logic                           trig_n_o;
   logic                           scaler_o;

   modport master (
      output trigger_i, power_i, mask_i, slow_ce_i, sync_i, trig_oneshot_i, delay_i,
      input  trig_p_o, trig_n_o, scaler_o
   );

   modport slave (
      input  trigger_i, power_i, mask_i, slow_ce_i, sync_i, trig_oneshot_i, delay_i,
      output trig_p_o, trig_n_o, scaler_o
   );
endinterface

// File: rtl/trigger_channel_scaler_v5.sv
// Per-channel L1 trigger conditioner: synchronizer, edge detect, programmable delay,
// retriggerable one-shot, scaler pulse and stuck-on detection.
`timescale 1ns/1ps
module trigger_channel_scaler_v5 #(
   parameter string       POLARITY            = "POSITIVE",
   parameter int unsigned TRIG_ONESHOT_BITS   = 4,
   parameter int unsigned TRIG_DELAY_VAL_BITS = 4,
   parameter int unsigned STUCK_CE_COUNT      = 2
) (
   input logic                        fast_clk_i,
   input logic                        rst_i,
   trigger_channel_scaler_v5_if.slave bus
);
   localparam bit          INVERT    = (POLARITY == "NEGATIVE");
   localparam int unsigned TAPS      = 2 ** TRIG_DELAY_VAL_BITS;
   localparam int unsigned STUCK_W   = $clog2(STUCK_CE_COUNT + 1);
   localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CE_COUNT);

   logic                         active_lvl;
   logic                         s1_q, s2_q, s3_q;
   logic                         rise;
   logic [TAPS-2:0]              pipe_q;
   logic [TAPS-1:0]              taps;
   logic                         dly_rise;
   logic [TRIG_ONESHOT_BITS-1:0] os_cnt_q, os_cnt_d;
   logic                         active_q, active_d;
   logic [STUCK_W-1:0]           stuck_cnt_q, stuck_cnt_d;
   logic                         stuck_q, stuck_d;
   logic                         trig_p_q, trig_n_q, scaler_q;

   assign active_lvl = bus.trigger_i ^ INVERT;
   assign rise       = s2_q & ~s3_q;
   // Tap 0 is the undelayed edge; tap d is the edge d cycles later.
   assign taps       = {pipe_q, rise};
   assign dly_rise   = taps[bus.delay_i];

   // Synchronizer, edge history and delay line.
   always_ff @(posedge fast_clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         pipe_q <= '0;
      end else begin
         s1_q   <= active_lvl;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         pipe_q <= taps[TAPS-2:0];
      end
   end

   // One-shot next state: a delayed edge (re)loads the length, otherwise count down.
   always_comb begin
      os_cnt_d = os_cnt_q;
      active_d = active_q;
      if (dly_rise) begin
         os_cnt_d = bus.trig_oneshot_i;
         active_d = 1'b1;
      end else if (active_q) begin
         if (os_cnt_q == '0) begin
            active_d = 1'b0;
         end else begin
            os_cnt_d = os_cnt_q - TRIG_ONESHOT_BITS'(1);
         end
      end
   end

   // Stuck next state: count slow enables while high, saturate, clear on any low level.
   always_comb begin
      stuck_cnt_d = stuck_cnt_q;
      if (!s2_q) begin
         stuck_cnt_d = '0;
      end else if (bus.slow_ce_i && (stuck_cnt_q != STUCK_MAX)) begin
         stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
      end
      stuck_d = s2_q && (stuck_cnt_d == STUCK_MAX);
   end

   // One-shot and stuck state registers.
   always_ff @(posedge fast_clk_i or posedge rst_i) begin
      if (rst_i) begin
         os_cnt_q    <= '0;
         active_q    <= 1'b0;
         stuck_cnt_q <= '0;
         stuck_q     <= 1'b0;
      end else begin
         os_cnt_q    <= os_cnt_d;
         active_q    <= active_d;
         stuck_cnt_q <= stuck_cnt_d;
         stuck_q     <= stuck_d;
      end
   end

   // Rising-edge outputs; mask only gates the trigger, power gates everything.
   always_ff @(posedge fast_clk_i or posedge rst_i) begin
      if (rst_i) begin
         trig_p_q <= 1'b0;
         scaler_q <= 1'b0;
      end else begin
         trig_p_q <= active_q & bus.power_i & ~bus.mask_i & ~stuck_q;
         if (!bus.power_i) begin
            scaler_q <= 1'b0;
         end else if (stuck_q) begin
            scaler_q <= bus.sync_i;
         end else begin
            scaler_q <= rise;
         end
      end
   end

   // Half-cycle shifted copy of the trigger for the falling-edge consumer.
   always_ff @(negedge fast_clk_i or posedge rst_i) begin
      if (rst_i) begin
         trig_n_q <= 1'b0;
      end else begin
         trig_n_q <= trig_p_q;
      end
   end

   assign bus.trig_p_o = trig_p_q;
   assign bus.trig_n_o = trig_n_q;
   assign bus.scaler_o = scaler_q;
endmodule

// File: tb/tb_trigger_channel_scaler_v5.sv
// Self-checking bench: per-cycle expected outputs are queued when a stimulus pattern is
// applied and popped as the DUT produces each cycle's outputs.
`timescale 1ns/1ps
module tb_trigger_channel_scaler_v5;
   localparam int OB = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          trig_pos, trig_neg, power, mask, slow_ce, sync;
   logic [OB-1:0] oneshot;
   logic [DB-1:0] delay;
   bit            use_neg;
   int            n_checks = 0;
   int            n_fail   = 0;

   // s: 0 or 1 literal scaler value, 2 means "equals sync_i as sampled at that edge"
   typedef struct {
      logic p;
      int   s;
   } exp_t;
   exp_t sb[$];

   trigger_channel_scaler_v5_if #(.TRIG_ONESHOT_BITS(OB), .TRIG_DELAY_VAL_BITS(DB)) bus_pos ();
   trigger_channel_scaler_v5_if #(.TRIG_ONESHOT_BITS(OB), .TRIG_DELAY_VAL_BITS(DB)) bus_neg ();

   assign bus_pos.trigger_i      = trig_pos;
   assign bus_pos.power_i        = power;
   assign bus_pos.mask_i         = mask;
   assign bus_pos.slow_ce_i      = slow_ce;
   assign bus_pos.sync_i         = sync;
   assign bus_pos.trig_oneshot_i = oneshot;
   assign bus_pos.delay_i        = delay;
   assign bus_neg.trigger_i      = trig_neg;
   assign bus_neg.power_i        = power;
   assign bus_neg.mask_i         = mask;
   assign bus_neg.slow_ce_i      = slow_ce;
   assign bus_neg.sync_i         = sync;
   assign bus_neg.trig_oneshot_i = oneshot;
   assign bus_neg.delay_i        = delay;

   trigger_channel_scaler_v5 #(
      .POLARITY("POSITIVE"), .TRIG_ONESHOT_BITS(OB), .TRIG_DELAY_VAL_BITS(DB),
      .STUCK_CE_COUNT(2)
   ) dut_pos (
      .fast_clk_i(clk), .rst_i(rst), .bus(bus_pos)
   );

   trigger_channel_scaler_v5 #(
      .POLARITY("NEGATIVE"), .TRIG_ONESHOT_BITS(OB), .TRIG_DELAY_VAL_BITS(DB),
      .STUCK_CE_COUNT(2)
   ) dut_neg (
      .fast_clk_i(clk), .rst_i(rst), .bus(bus_neg)
   );

   logic obs_p, obs_n, obs_s;
   assign obs_p = use_neg ? bus_neg.trig_p_o : bus_pos.trig_p_o;
   assign obs_n = use_neg ? bus_neg.trig_n_o : bus_pos.trig_n_o;
   assign obs_s = use_neg ? bus_neg.scaler_o : bus_pos.scaler_o;

   always #5 clk = ~clk;

   // Shared toggle changes at the falling edge so it is stable around every rising edge.
   initial begin
      sync = 1'b0;
      forever begin
         @(negedge clk);
         sync = ~sync;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1);
   end

   // Drive the selected channel's line to the active (1) or idle (0) level.
   task automatic drive(input logic act);
      if (use_neg) begin
         trig_neg = ~act;
         trig_pos = 1'b0;
      end else begin
         trig_pos = act;
         trig_neg = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      drive(1'b0);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Queue expectations for edges 1..len from the timing rules.
   task automatic push_window(input int len, input logic [63:0] smask, input int p_from,
                              input int p_to, input int y_from, input int y_to);
      exp_t e;
      for (int k = 1; k <= len; k++) begin
         e.p = (k >= p_from) && (k <= p_to);
         e.s = ((k >= y_from) && (k <= y_to)) ? 2 : int'(smask[k]);
         sb.push_back(e);
      end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      rst = 1'b1; power = 1'b1; mask = 1'b0; slow_ce = 1'b0;
      oneshot = '0; delay = '0; use_neg = 1'b0;
      trig_pos = 1'b1; trig_neg = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); #1;
         if (k >= 4) trig_pos = 1'b0;
         got = {bus_pos.scaler_o, bus_pos.trig_p_o, bus_pos.trig_n_o,
                bus_neg.scaler_o, bus_neg.trig_p_o, bus_neg.trig_n_o};
         if (k == 5) rst = 1'b0;
         n_checks++;
         if (got !== 6'b0) begin
            n_fail++;
            $display("FAIL reset step %0d: outputs got %b want 000000", k, got);
         end
      end
      idle(4);
   endtask

   task automatic test_pulse(input string name, input logic neg, input logic [63:0] pat,
                             input int d, input int n, input logic [63:0] smask,
                             input int p_from, input int p_to, input int len);
      exp_t       e;
      logic [2:0] got, want;
      logic       sy;
      use_neg = neg;
      delay   = DB'(d);
      oneshot = OB'(n);
      idle(2);
      push_window(len, smask, p_from, p_to, 0, -1);
      for (int k = 1; k <= len; k++) begin
         drive(pat[k]);
         @(posedge clk); #1;
         got[2] = obs_s; got[1] = obs_p; sy = sync;
         @(negedge clk); #1;
         got[0] = obs_n;
         e = sb.pop_front();
         want = {(e.s == 2) ? sy : e.s[0], e.p, e.p};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s edge %0d: scaler/p/n got %b want %b", name, k, got, want);
         end
      end
      idle(20);
   endtask

   task automatic test_stuck();
      exp_t       e;
      logic [2:0] got, want;
      logic       sy;
      use_neg = 1'b0; delay = '0; oneshot = '0;
      idle(2);
      // initial edge fires once, stuck after the 2nd slow_ce (edge 10), release after edge 20
      push_window(30, 64'h8, 4, 4, 11, 23);
      for (int k = 1; k <= 30; k++) begin
         drive(k <= 20);
         slow_ce = (k == 6) || (k == 10) || (k == 14);
         @(posedge clk); #1;
         got[2] = obs_s; got[1] = obs_p; sy = sync;
         slow_ce = 1'b0;
         @(negedge clk); #1;
         got[0] = obs_n;
         e = sb.pop_front();
         want = {(e.s == 2) ? sy : e.s[0], e.p, e.p};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL stuck edge %0d: scaler/p/n got %b want %b", k, got, want);
         end
      end
      idle(10);
   endtask

   task automatic test_reset_mid();
      exp_t       e;
      logic [2:0] got, want;
      use_neg = 1'b0; delay = '0; oneshot = 4'd7;
      idle(2);
      push_window(6, 64'h8, 4, 11, 0, -1);
      for (int k = 1; k <= 6; k++) begin
         drive(k <= 3);
         @(posedge clk); #1;
         got[2] = obs_s; got[1] = obs_p;
         @(negedge clk); #1;
         got[0] = obs_n;
         e = sb.pop_front();
         want = {e.s[0], e.p, e.p};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid edge %0d: scaler/p/n got %b want %b", k, got, want);
         end
      end
      rst = 1'b1;
      #1;
      got = {obs_s, obs_p, obs_n};
      n_checks++;
      if (got !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid immediate: scaler/p/n got %b want 000", got);
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         got = {obs_s, obs_p, obs_n};
         n_checks++;
         if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid held %0d: scaler/p/n got %b want 000", k, got);
         end
      end
      @(negedge clk); #1;
      rst = 1'b0;
      idle(20);
   endtask

   initial begin
      test_reset();
      test_pulse("single", 1'b0, 64'b1110, 0, 0, 64'h8, 4, 4, 12);
      test_pulse("delay", 1'b0, 64'b1110, 5, 3, 64'h8, 9, 12, 18);
      test_pulse("negative", 1'b1, 64'b110, 0, 0, 64'h8, 4, 4, 12);
      mask = 1'b1;
      test_pulse("mask", 1'b0, 64'b1110, 0, 2, 64'h8, 1, 0, 12);
      mask = 1'b0;
      power = 1'b0;
      test_pulse("power", 1'b0, 64'b1110, 0, 2, 64'h0, 1, 0, 12);
      power = 1'b1;
      test_stuck();
      test_pulse("after_stuck", 1'b0, 64'b1110, 0, 0, 64'h8, 4, 4, 12);
      test_pulse("back_to_back", 1'b0, 64'b11010, 0, 7, 64'h28, 4, 13, 18);
      test_reset_mid();
      test_pulse("after_reset", 1'b0, 64'b1110, 2, 1, 64'h8, 6, 7, 12);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/trigger_channel_scaler_v5.md
# trigger_channel_scaler_v5

Per-channel L1 trigger conditioner for one daughterboard trigger line. It sits inside the trigger scaler map, one instance per TDA or reserve channel. It synchronizes the asynchronous comparator output and applies polarity, a programmable delay and a programmable one-shot width. It produces edge-aligned trigger outputs plus a scaler pulse with stuck-on detection.

## Interface
Parameters:
- POLARITY, "POSITIVE": "NEGATIVE" inverts trigger_i before all processing.
- TRIG_ONESHOT_BITS, 4: width of trig_oneshot_i.
- TRIG_DELAY_VAL_BITS, 4: width of delay_i.
- STUCK_CE_COUNT, 2: number of slow_ce_i pulses of continuous active level before the line is declared stuck.

Ports:
- fast_clk_i, in, 1: the only clock. trig_n_o uses its falling edge.
- rst_i, in, 1: asynchronous, active-high reset.
- trigger_i, in, 1: asynchronous trigger line.
- power_i, in, 1: channel powered or selected. Gates all outputs.
- mask_i, in, 1: suppresses trig_p_o and trig_n_o only.
- slow_ce_i, in, 1: single-cycle enable on fast_clk_i, nominally 1 MHz. Used for stuck timing.
- sync_i, in, 1: shared toggle, inverts every fast_clk_i cycle. Drives stuck scaler pattern.
- trig_oneshot_i, in, TRIG_ONESHOT_BITS: one-shot length minus 1.
- delay_i, in, TRIG_DELAY_VAL_BITS: delay in fast_clk_i cycles.
- trig_p_o, out, 1: trigger, registered on rising edge.
- trig_n_o, out, 1: trig_p_o re-registered on falling edge.
- scaler_o, out, 1: one-cycle pulse per trigger edge, or the sync_i pattern while stuck.

## Operation
- Active level a = trigger_i, inverted if POLARITY is "NEGATIVE".
- a passes through a 2-flop synchronizer, giving s2.
- A third flop s3 forms edge = s2 & !s3.
- The edge pipeline is a shift register of 2^TRIG_DELAY_VAL_BITS stages. Its output tap is selected by delay_i; delay_i=0 means no extra delay.
- One-shot:
  - The delayed edge loads counter = trig_oneshot_i and sets active.
  - active stays high for trig_oneshot_i+1 cycles.
  - A new delayed edge while active reloads the counter, extending the pulse.
- trig_p_o is registered as active & power_i & !mask_i & !stuck.
- trig_n_o samples trig_p_o on the falling edge of fast_clk_i.
- scaler_o, registered:
  - If power_i=0: 0.
  - Else if stuck: sync_i.
  - Else: edge.
  - mask_i has no effect on scaler_o.
- Stuck detection:
  - A counter advances on each slow_ce_i while s2=1 and clears whenever s2=0.
  - When the counter reaches STUCK_CE_COUNT, stuck sets. The counter saturates.
  - stuck clears on the first cycle s2=0.
  - A new edge is required after a stuck line returns to active.
- Inputs power_i, mask_i, trig_oneshot_i and delay_i are quasi-static. Changes take effect at the next use, with no glitch requirement.
- Reset clears the synchronizer, pipeline, counters and stuck. All outputs are 0 during and after reset.

## Timing
- Edge 1 is the first rising edge that samples trigger_i active.
- s2 is high after edge 2. edge is true between edge 2 and edge 3.
- scaler_o is high for exactly one cycle, after edge 3.
- trig_p_o rises after edge 4+delay_i and stays high for trig_oneshot_i+1 cycles.
- trig_n_o follows trig_p_o half a cycle later.
- Input pulses shorter than one fast_clk_i period may be missed. Pulses of 2 or more cycles must be caught.
- Two edges need s2 low for at least 1 cycle between them. Each edge gives one scaler pulse.
- Stuck asserts on the cycle after the STUCK_CE_COUNT-th slow_ce_i seen with s2=1. From then on, scaler_o follows sync_i delayed by 1 cycle.
- If reset is asserted mid-one-shot or mid-stuck, outputs drop asynchronously and immediately.

## Test plan
- Single pulse, POSITIVE, delay_i=0, trig_oneshot_i=0: trigger_i high for 3 cycles -> scaler_o 1 cycle after edge 3; trig_p_o 1 cycle after edge 4; trig_n_o half a cycle later.
- delay_i=5, trig_oneshot_i=3 -> trig_p_o rises after edge 9, high for 4 cycles; scaler timing unchanged.
- NEGATIVE polarity: trigger_i idles high and pulses low for 2 cycles -> same response as the positive case. Idle-high with POSITIVE, held past STUCK_CE_COUNT slow_ce_i pulses -> stuck, scaler_o follows sync_i.
- mask_i=1 -> trig_p_o and trig_n_o stay 0; scaler_o pulses normally. power_i=0 -> all outputs 0.
- Stuck: trigger_i held high while 3 slow_ce_i pulses arrive -> scaler_o toggles with sync_i and trig_p_o stays 0 after the initial one-shot. Release trigger_i -> scaler_o returns to 0 within 4 cycles. The next pulse is counted normally.
- Retrigger and reset: second edge 2 cycles after the first with trig_oneshot_i=7 -> trig_p_o extended to end 8 cycles after the second start. rst_i=1 mid-pulse -> all outputs 0 immediately.
